uart_tx_controller: RTL
=======================

UART_TX_CONTROLLER -- requirements
Module: uart_tx_controller

Interface
REQ-001 Parameter SIZE SHALL default to 4 and give the data word width in bits (SIZE >= 1).
REQ-002 Parameter CLKS_PER_BIT SHALL default to 16 and give the clock cycles per serial bit (CLKS_PER_BIT >= 2).
REQ-003 There SHALL be one clock; reset is asynchronous and active-high.
REQ-004 Port clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 Port rst  input  1  SHALL be the asynchronous active-high reset.
REQ-006 Port tx_start  input  1  SHALL be the request to send one frame.
REQ-007 Port tx_data  input  SIZE  SHALL be the word to send, sampled on acceptance.
REQ-008 Port parity_en  input  1  SHALL add a parity bit when 1, sampled on acceptance.
REQ-009 Port parity_odd  input  1  SHALL select odd parity when 1 and even parity when 0, sampled on acceptance.
REQ-010 Port tx  output  1  SHALL be the serial line, idle high.
REQ-011 Port tx_busy  output  1  SHALL be 1 from the cycle after acceptance until the stop bit ends.
REQ-012 Port tx_done  output  1  SHALL give a one-cycle pulse at frame completion.

Function
REQ-013 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-014 In IDLE with tx_start=1, the block SHALL latch tx_data, parity_en and parity_odd and enter START on the next edge.
REQ-015 tx_start SHALL be ignored in every state other than IDLE; the latched data SHALL stay unchanged until the frame ends.
REQ-016 An internal bit-timer SHALL count 0..CLKS_PER_BIT-1 and reset to 0 on every state change; each bit SHALL be held for exactly CLKS_PER_BIT cycles.
REQ-017 START SHALL drive tx=0 and then go to DATA.
REQ-018 DATA SHALL send the latched word LSB first, one bit per bit period, using an index counter 0..SIZE-1; after bit SIZE-1 it SHALL go to PARITY if parity_en was latched as 1, otherwise to STOP.
REQ-019 The parity bit SHALL be the XOR-reduction of the latched word for even parity and its inverse for odd parity, computed from the latched word, not the live tx_data.
REQ-020 PARITY SHALL drive the parity bit for one bit period and then go to STOP.
REQ-021 STOP SHALL drive tx=1 for one bit period and then go to IDLE.
REQ-022 tx_done SHALL be 1 in the first IDLE cycle after STOP and 0 in all other cycles.
REQ-023 A tx_start in that same first IDLE cycle SHALL be accepted, giving back-to-back frames with no extra idle bit.
REQ-024 tx_busy SHALL be 1 in START, DATA, PARITY and STOP and 0 in IDLE.
REQ-025 A frame SHALL last (2+SIZE+P)*CLKS_PER_BIT busy cycles, where P is the latched parity_en.
REQ-026 tx SHALL be registered with no combinational path from inputs to tx, tx_busy or tx_done.

Reset
REQ-027 When rst=1, the block SHALL immediately, without waiting for a clock edge, set state=IDLE, tx=1, tx_busy=0, tx_done=0 and all counters and latched registers to 0.
REQ-028 A reset during any frame SHALL abort the frame with no tx_done pulse; tx_start while rst=1 SHALL be ignored.
REQ-029 After rst falls, the first tx_start SHALL be accepted on the next rising edge.

Verification (SIZE=8, CLKS_PER_BIT=4)
REQ-030 Even parity: tx_data=8'hA5, parity_en=1, parity_odd=0 -> tx=0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, parity 0, stop 1; tx_busy high for 44 cycles; one tx_done pulse.
REQ-031 Odd parity: 8'h01, parity_en=1, parity_odd=1 -> parity bit 0; 8'h00 with odd parity -> parity bit 1.
REQ-032 No parity: 8'hFF, parity_en=0 -> start 0, eight 1s, stop 1; tx_busy high for 40 cycles.
REQ-033 Busy rejection: tx_start held with tx_data=8'h3C, then tx_data changed to 8'hC3 mid-frame with tx_start still high -> 8'h3C is sent once; 8'hC3 is sent only after tx_done, as the back-to-back frame.
REQ-034 Reset mid-frame: assert rst during DATA bit 3 -> tx=1 and tx_busy=0 at once, no tx_done; a new frame with 8'h5A after reset is sent correctly.
REQ-035 Back-to-back: tx_start asserted in the tx_done cycle -> the next START bit begins on the following edge, with no idle gap beyond the stop bit.

Source files
------------

// File: rtl/uart_tx_controller.sv
// UART transmitter: start bit, SIZE data bits LSB first, optional even/odd parity, one stop bit.
// All outputs are registered; each bit is held for CLKS_PER_BIT clock cycles.
module uart_tx_controller #(
    parameter int SIZE         = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tx_start,
    input  logic [SIZE-1:0] tx_data,
    input  logic            parity_en,
    input  logic            parity_odd,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done
);

    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state;
    logic [TMR_W-1:0]  timer;
    logic [IDX_W-1:0]  bit_idx;
    logic [IDX_W-1:0]  next_idx;
    logic [SIZE-1:0]   data_reg;
    logic              par_en_reg;
    logic              par_odd_reg;
    logic              bit_end;

    assign bit_end  = (timer == LAST_TICK);
    assign next_idx = bit_idx + IDX_W'(1);

    // tx is loaded with the value of the next bit at the same edge the state advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tx          <= 1'b1;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            timer       <= '0;
            bit_idx     <= '0;
            data_reg    <= '0;
            par_en_reg  <= 1'b0;
            par_odd_reg <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    timer   <= '0;
                    bit_idx <= '0;
                    tx      <= 1'b1;
                    if (tx_start) begin
                        data_reg    <= tx_data;
                        par_en_reg  <= parity_en;
                        par_odd_reg <= parity_odd;
                        tx          <= 1'b0;
                        tx_busy     <= 1'b1;
                        state       <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        timer <= '0;
                        tx    <= data_reg[0];
                        state <= DATA;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        timer <= '0;
                        if (bit_idx == LAST_BIT) begin
                            bit_idx <= '0;
                            if (par_en_reg) begin
                                tx    <= (^data_reg) ^ par_odd_reg;
                                state <= PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_idx <= next_idx;
                            tx      <= data_reg[next_idx];
                        end
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        timer <= '0;
                        tx    <= 1'b1;
                        state <= STOP;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        timer   <= '0;
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: begin
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                    timer   <= '0;
                    bit_idx <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
